// File: rtl/pb_scanner.sv
// +---------------------------------------------------------------------------+
// | pb_scanner: debounced 16-button scanner with press strobe and counter.    |
// | Optional auto-repeat via `define PB_SCANNER_AUTOREPEAT_EN. Rev 1.0        |
// +---------------------------------------------------------------------------+
`default_nettype none

module pb_scanner #(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int REPEAT_TICKS   = 25
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [15:0] pb,
  output logic [3:0]  code,
  output logic        strobe,
  output logic        valid,
  output logic [15:0] level,
  output logic [7:0]  count
);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_debounce = 2'd1;
  localparam logic [1:0] c_held     = 2'd2;
  localparam logic [1:0] c_release  = 2'd3;

  localparam logic [7:0] c_db_last = 8'(DEBOUNCE_TICKS - 1);

  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 255) begin : g_bad_debounce
    $error("pb_scanner: DEBOUNCE_TICKS must be in 2..255");
  end

  if (REPEAT_TICKS < 2 || REPEAT_TICKS > 255) begin : g_bad_repeat
    $error("pb_scanner: REPEAT_TICKS must be in 2..255");
  end

  logic [15:0] r_sync1;
  logic [15:0] r_spb;
  logic [1:0]  r_state;
  logic [7:0]  r_tick;
  logic [3:0]  w_cand;
  logic        w_any;
  logic        w_rep_fire;

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 16'd0;
      r_spb   <= 16'd0;
    end else begin
      r_sync1 <= pb;
      r_spb   <= r_sync1;
    end
  end

  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    w_cand = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_spb[i]) w_cand = 4'(i);
    end
  end

  assign w_any = |r_spb;

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state <= c_idle;
      r_tick  <= 8'd0;
      code    <= 4'd0;
      strobe  <= 1'b0;
      count   <= 8'd0;
    end else begin
      strobe <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_any) begin
            code    <= w_cand;
            r_tick  <= 8'd0;
            r_state <= c_debounce;
          end
        end
        c_debounce: begin
          if (!w_any || (w_cand != code)) begin
            r_state <= c_idle;
          end else if (r_tick == c_db_last) begin
            r_state <= c_held;
            strobe  <= 1'b1;
            count   <= count + 8'd1;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        c_held: begin
          // code stays locked here; extra or changed buttons are ignored
          if (!w_any) begin
            r_tick  <= 8'd0;
            r_state <= c_release;
          end else if (w_rep_fire) begin
            strobe <= 1'b1;
            count  <= count + 8'd1;
          end
        end
        c_release: begin
          if (w_any) begin
            r_state <= c_held;
          end else if (r_tick == c_db_last) begin
            r_state <= c_idle;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef PB_SCANNER_AUTOREPEAT_EN
  localparam logic [7:0] c_rep_last = 8'(REPEAT_TICKS - 1);

  logic [7:0] r_rep;

  // Held-cycle count survives RELEASE (cleared on entry) so a bounce back to
  // HELD continues from zero rather than restarting a fresh qualification.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_rep <= 8'd0;
    end else if (r_state == c_held && w_any && r_rep != c_rep_last) begin
      r_rep <= r_rep + 8'd1;
    end else if (r_state != c_release) begin
      r_rep <= 8'd0;
    end
  end

  assign w_rep_fire = (r_state == c_held) && w_any && (r_rep == c_rep_last);
`else
  assign w_rep_fire = 1'b0;
`endif

  assign valid = (r_state == c_held) || (r_state == c_release);
  assign level = valid ? (16'd1 << code) : 16'd0;

endmodule

`default_nettype wire

// File: tb/tb_pb_scanner.sv
// +---------------------------------------------------------------------------+
// | tb_pb_scanner: scoreboard bench for pb_scanner. Rev 1.0                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_pb_scanner;

  localparam int DB = 5;
  localparam int RT = 25;
`ifdef PB_SCANNER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        hz100 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pb    = 16'd0;
  logic [3:0]  code;
  logic        strobe;
  logic        valid;
  logic [15:0] level;
  logic [7:0]  count;

  pb_scanner #(.DEBOUNCE_TICKS(DB), .REPEAT_TICKS(RT)) dut (
    .hz100 (hz100),
    .reset (reset),
    .pb    (pb),
    .code  (code),
    .strobe(strobe),
    .valid (valid),
    .level (level),
    .count (count)
  );

  always #5 hz100 = ~hz100;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] cnt;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_count = 8'd0;
  logic       prev_strobe = 1'b0;

  always @(posedge hz100) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic expect_strobe(input logic [3:0] c, input int at);
    exp_count = exp_count + 8'd1;
    sb.push_back('{code: c, cnt: exp_count, cyc: at});
  endtask

  // Clean press from IDLE: strobe is seen DB+3 negedges after the drive.
  task automatic press(input int idx);
    pb = 16'd1 << idx;
    expect_strobe(4'(idx), cyc + DB + 3);
  endtask

  always @(negedge hz100) begin
    if (strobe) begin
      chk("strobe_consec", {31'd0, prev_strobe}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexp_strobe", {31'd0, strobe}, 32'd0);
      end else begin : b_pop
        ev_t e;
        e = sb.pop_front();
        chk("sb_code", 32'(code), 32'(e.code));
        chk("sb_count", 32'(count), 32'(e.cnt));
        chk("sb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_strobe = strobe;
  end

  initial begin
    tick(3);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    tick(2);

    // Single clean press of button 3
    press(3);
    tick(10);
    chk("p3_code", 32'(code), 32'd3);
    chk("p3_level", 32'(level), 32'h0008);
    chk("p3_valid", 32'(valid), 32'd1);
    chk("p3_count", 32'(count), 32'd1);
    pb = 16'd0;
    tick(10);
    chk("p3_rel_valid", 32'(valid), 32'd0);

    // Short glitch never qualifies
    pb = 16'h0200;
    tick(3);
    chk("glitch_valid_mid", 32'(valid), 32'd0);
    pb = 16'd0;
    tick(10);
    chk("glitch_valid", 32'(valid), 32'd0);
    chk("glitch_count", 32'(count), 32'(exp_count));

    // Higher button joins during DEBOUNCE: restart, one extra cycle latency
    pb = 16'h0004;
    tick(3);
    pb = 16'h4004;
    expect_strobe(4'd14, cyc + DB + 4);
    tick(12);
    pb = 16'h4024;
    tick(5);
    chk("lock_code", 32'(code), 32'd14);
    chk("lock_level", 32'(level), 32'h4000);
    chk("lock_valid", 32'(valid), 32'd1);
    pb = 16'd0;
    tick(10);
    chk("lock_rel_valid", 32'(valid), 32'd0);

    // Brief release keeps the press; a long release ends it
    press(7);
    tick(12);
    pb = 16'd0;
    tick(2);
    pb = 16'h0080;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("bounce_valid", 32'(valid), 32'd1);
    end
    chk("bounce_level", 32'(level), 32'h0080);
    pb = 16'd0;
    tick(7);
    chk("rel_valid_hold", 32'(valid), 32'd1);
    tick(1);
    chk("rel_valid_drop", 32'(valid), 32'd0);

    // Asynchronous reset mid-DEBOUNCE
    pb = 16'h0800;
    tick(4);
    chk("pre_rst_code", 32'(code), 32'd11);
    chk("pre_rst_valid", 32'(valid), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("arst_code", 32'(code), 32'd0);
    chk("arst_strobe", 32'(strobe), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    tick(3);
    chk("rst_hold_valid", 32'(valid), 32'd0);
    reset = 1'b1;
    exp_count = 8'd0;
    expect_strobe(4'd11, cyc + DB + 3);
    tick(DB + 2);
    chk("requal_early", 32'(count), 32'd0);
    tick(3);
    chk("requal_valid", 32'(valid), 32'd1);
    chk("requal_count", 32'(count), 32'd1);
    pb = 16'd0;
    tick(10);

    // 256 presses since reset wrap the counter to zero
    for (int i = 0; i < 255; i++) begin
      press(i % 16);
      tick(9);
      pb = 16'd0;
      tick(8);
    end
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_valid", 32'(valid), 32'd0);

    // Long hold: repeats only with the auto-repeat build
    pb = 16'h0001;
    begin : b_hold
      int t0;
      t0 = cyc;
      expect_strobe(4'd0, t0 + DB + 3);
      if (AR) begin
        expect_strobe(4'd0, t0 + DB + 3 + RT);
        expect_strobe(4'd0, t0 + DB + 3 + 2 * RT);
      end
    end
    tick(DB + 3 + 60);
    chk("hold_count", 32'(count), AR ? 32'd3 : 32'd1);
    chk("hold_code", 32'(code), 32'd0);
    pb = 16'd0;
    tick(12);
    chk("final_valid", 32'(valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pb_scanner.md
PB_SCANNER -- requirements
Module: pb_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 5, meaning consecutive stable synchronized cycles that qualify a press or release (legal 2..255).
REQ-002 SHALL have parameter REPEAT_TICKS, default 25, meaning the held-cycle period between auto-repeat strobes (legal 2..255).
REQ-003 SHALL have port hz100, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset, asserted when 0.
REQ-005 SHALL have port pb, input, 16 bits: raw asynchronous pushbutton levels, 1 = pressed.
REQ-006 SHALL have port code, output, 4 bits: index of the qualified button.
REQ-007 SHALL have port strobe, output, 1 bit: single-cycle press event.
REQ-008 SHALL have port valid, output, 1 bit: a qualified button is held.
REQ-009 SHALL have port level, output, 16 bits: one-hot of code while valid, else 0; this drives the downstream bargraph.
REQ-010 SHALL have port count, output, 8 bits: number of strobes issued.

Function
REQ-011 SHALL pass pb through a two-flop synchronizer; all further logic uses only the synchronized value (spb).
REQ-012 SHALL priority-encode spb, with the highest set index winning ("cand").
REQ-013 SHALL implement FSM states IDLE, DEBOUNCE, HELD and RELEASE, plus an 8-bit tick counter.
REQ-014 In IDLE, if spb is nonzero, SHALL latch code = cand, clear the counter and enter DEBOUNCE.
REQ-015 In DEBOUNCE, if spb is zero or cand differs from code, SHALL return to IDLE; otherwise SHALL increment the counter.
REQ-016 In DEBOUNCE, when the counter equals DEBOUNCE_TICKS-1, SHALL enter HELD, pulse strobe for exactly one cycle and increment count.
REQ-017 Latency: with pb stable from before edge k, strobe SHALL be high in the cycle after edge k+2+DEBOUNCE_TICKS.
REQ-018 In HELD, code SHALL stay locked, and additional or changed buttons SHALL be ignored; when spb is zero, SHALL clear the counter and enter RELEASE.
REQ-019 In RELEASE, if spb is nonzero, SHALL return to HELD without a strobe.
REQ-020 In RELEASE, after DEBOUNCE_TICKS consecutive zero cycles, SHALL enter IDLE.
REQ-021 valid SHALL be 1 in HELD and RELEASE, and 0 in IDLE and DEBOUNCE; level SHALL follow REQ-009.
REQ-022 count SHALL wrap from 255 to 0 without saturation.
REQ-023 strobe SHALL never be high on two consecutive cycles.

Reset
REQ-024 Reset assertion SHALL immediately, independent of hz100, clear the synchronizer, counter and FSM (to IDLE), and set code=0, strobe=0, valid=0, level=0 and count=0.
REQ-025 Reset asserted mid-press SHALL discard the press; after release, a still-held button SHALL requalify through the full DEBOUNCE path.
REQ-026 Reset deassertion SHALL take effect on the next hz100 edge, with no spurious strobe.

Configuration
REQ-027 Macro PB_SCANNER_AUTOREPEAT_EN, when defined, SHALL cause HELD to count held cycles and, every REPEAT_TICKS cycles, pulse strobe and increment count while the button stays held.
REQ-028 The HELD-cycle count SHALL reset on entry to RELEASE and SHALL not restart on a RELEASE-to-HELD return.
REQ-029 Without PB_SCANNER_AUTOREPEAT_EN, exactly one strobe SHALL occur per qualified press, and no repeat logic SHALL be synthesized.

Verification (DEBOUNCE_TICKS=5, REPEAT_TICKS=25)
REQ-030 pb[3]=1 before edge 0, held -> strobe high only after edge 7, code=3, level=16'h0008, valid=1, count=1.
REQ-031 pb[9] glitch high for 3 cycles -> no strobe, valid stays 0, count unchanged.
REQ-032 pb[2] then pb[14] pressed during DEBOUNCE -> return to IDLE, then qualify code=14; pb[5] added while HELD -> code stays 14.
REQ-033 Held button released for 2 cycles, then pressed again -> valid stays 1, no second strobe; released for 6 cycles -> valid=0.
REQ-034 256 qualified presses -> count=0; reset pulsed low mid-DEBOUNCE -> all outputs 0 asynchronously, then a full requalification is required.
REQ-035 With the macro, pb[0] held 60 cycles after strobe -> two additional strobes 25 cycles apart and count=3; without the macro, count=1.
